// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the immediate decode stage.
// Imported by imm_extract and imm_decode_stage.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_CSR  = 3'd5,
        IMM_NONE = 3'd6,
        IMM_ILL  = 3'd7
    } imm_type_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/imm_extract.sv
// Combinational opcode-driven immediate extraction.
// Produces the XLEN-wide extended immediate and its format type.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type
);

    logic [31:0] imm32;

    // Classify the word by opcode; SYSTEM splits on funct3[2].
    always_comb begin
        imm_type = IMM_ILL;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR: imm_type = IMM_I;
            OP_STORE:                 imm_type = IMM_S;
            OP_BRANCH:                imm_type = IMM_B;
            OP_LUI, OP_AUIPC:         imm_type = IMM_U;
            OP_JAL:                   imm_type = IMM_J;
            OP_SYSTEM:
                imm_type = instr[14] ? IMM_CSR : IMM_I;
            OP_OP, OP_FENCE:          imm_type = IMM_NONE;
            default:                  imm_type = IMM_ILL;
        endcase
    end

    // Assemble the 32-bit immediate for each format.
    always_comb begin
        imm32 = '0;
        unique case (imm_type)
            IMM_I:
                imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:
                imm32 = {{20{instr[31]}}, instr[31:25],
                         instr[11:7]};
            IMM_B:
                imm32 = {{19{instr[31]}}, instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
            IMM_U:
                imm32 = {instr[31:12], 12'b0};
            IMM_J:
                imm32 = {{11{instr[31]}}, instr[31],
                         instr[19:12], instr[20],
                         instr[30:21], 1'b0};
            IMM_CSR:
                imm32 = {27'b0, instr[19:15]};
            default:
                imm32 = '0;
        endcase
    end

    // CSR zimm has bit 31 clear, so sign extension is safe for all.
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode stage with a 2-entry output FIFO.
// Ready toward fetch depends only on registered occupancy.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output imm_type_e        out_imm_type,
    output logic [XLEN-1:0]  out_target,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        imm_type_e       imm_type;
        logic [XLEN-1:0] target;
    } entry_t;

    entry_t           mem_q [FIFO_DEPTH];
    entry_t           mem_d [FIFO_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

    logic [XLEN-1:0]  ext_imm;
    imm_type_e        ext_type;
    entry_t           new_entry;
    logic             push;
    logic             pop;

    imm_extract #(
        .XLEN(XLEN)
    ) u_extract (
        .instr    (in_instr),
        .imm      (ext_imm),
        .imm_type (ext_type)
    );

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // Build the entry, including the branch/jump target.
    always_comb begin
        new_entry          = '0;
        new_entry.instr    = in_instr;
        new_entry.pc       = in_pc;
        new_entry.imm      = ext_imm;
        new_entry.imm_type = ext_type;
        new_entry.target   = in_pc + ext_imm;
    end

    // FIFO pointers, occupancy and the saturating illegal count.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ill_cnt_d = ill_cnt_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = new_entry;
                wr_ptr_d        = ~wr_ptr_q;
                if (ext_type == IMM_ILL && ill_cnt_q != '1)
                    ill_cnt_d = ill_cnt_q + CNT_W'(1);
            end
            if (pop)
                rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset clears all storage immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            ill_cnt_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    assign out_instr    = mem_q[rd_ptr_q].instr;
    assign out_pc       = mem_q[rd_ptr_q].pc;
    assign out_imm      = mem_q[rd_ptr_q].imm;
    assign out_imm_type = mem_q[rd_ptr_q].imm_type;
    assign out_target   = mem_q[rd_ptr_q].target;
    assign illegal_cnt  = ill_cnt_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32/CNT_W=2 and XLEN=64 instances.
// A queue model predicts every head entry; directed checks pin it.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = '0;

    logic        rdy32, vld32;
    logic [31:0] oi32, opc32, oimm32, otgt32;
    logic [2:0]  oty32;
    logic [1:0]  ill32;

    logic        rdy64, vld64;
    logic [31:0] oi64;
    logic [63:0] opc64, oimm64, otgt64;
    logic [2:0]  oty64;
    logic [15:0] ill64;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .CNT_W(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(vld32), .out_ready(out_ready),
        .out_instr(oi32), .out_pc(opc32), .out_imm(oimm32),
        .out_imm_type(oty32), .out_target(otgt32),
        .illegal_cnt(ill32)
    );

    imm_decode_stage #(.XLEN(64), .CNT_W(16)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(vld64), .out_ready(out_ready),
        .out_instr(oi64), .out_pc(opc64), .out_imm(oimm64),
        .out_imm_type(oty64), .out_target(otgt64),
        .illegal_cnt(ill64)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  ty;
    } exp_t;

    exp_t        q[$];
    int unsigned ill_seen = 0;

    task automatic chk(string name, logic [63:0] act,
                       logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    function automatic logic [63:0] sat(int unsigned v,
                                        int unsigned m);
        return (v > m) ? 64'(m) : 64'(v);
    endfunction

    // Immediate rules in 64-bit arithmetic; narrower XLEN truncates.
    function automatic exp_t model(logic [31:0] w,
                                   logic [63:0] pc);
        exp_t e;
        logic signed [63:0] s, s12, s20, s25, s31;
        s   = 64'($signed(w));
        s12 = s >>> 12;
        s20 = s >>> 20;
        s25 = s >>> 25;
        s31 = s >>> 31;
        e.instr = w;
        e.pc    = pc;
        e.imm   = 64'd0;
        e.ty    = 3'd7;
        case (w[6:0])
            7'h03, 7'h13, 7'h67: begin
                e.ty = 3'd0; e.imm = s20;
            end
            7'h73: begin
                if (w[14]) begin
                    e.ty = 3'd5; e.imm = 64'(w[19:15]);
                end else begin
                    e.ty = 3'd0; e.imm = s20;
                end
            end
            7'h23: begin
                e.ty  = 3'd1;
                e.imm = (s25 << 5) | 64'(w[11:7]);
            end
            7'h63: begin
                e.ty  = 3'd2;
                e.imm = (s31 << 12) | (64'(w[7]) << 11)
                      | (64'(w[30:25]) << 5)
                      | (64'(w[11:8]) << 1);
            end
            7'h37, 7'h17: begin
                e.ty = 3'd3; e.imm = s12 << 12;
            end
            7'h6F: begin
                e.ty  = 3'd4;
                e.imm = (s31 << 20) | (64'(w[19:12]) << 12)
                      | (64'(w[20]) << 11)
                      | (64'(w[30:21]) << 1);
            end
            7'h33, 7'h0F: e.ty = 3'd6;
            default:      e.ty = 3'd7;
        endcase
        return e;
    endfunction

    // Model state follows the handshake rules at each clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            ill_seen = 0;
        end else begin
            bit   mpush, mpop;
            exp_t e;
            mpush = in_valid && (q.size() != 2) && !flush;
            mpop  = (q.size() != 0) && out_ready && !flush;
            if (flush) begin
                q.delete();
            end else begin
                if (mpop) void'(q.pop_front());
                if (mpush) begin
                    e = model(in_instr, in_pc);
                    q.push_back(e);
                    if (e.ty == 3'd7) ill_seen++;
                end
            end
        end
    end

    // Compare both DUTs against the model every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t        e;
            logic [63:0] t;
            chk("valid32", vld32, q.size() != 0);
            chk("valid64", vld64, q.size() != 0);
            chk("ready32", rdy32, q.size() != 2);
            chk("ready64", rdy64, q.size() != 2);
            chk("ill32", ill32, sat(ill_seen, 3));
            chk("ill64", ill64, sat(ill_seen, 65535));
            if (q.size() != 0) begin
                e = q[0];
                t = e.pc + e.imm;
                chk("instr32", oi32, e.instr);
                chk("instr64", oi64, e.instr);
                chk("pc32", opc32, e.pc[31:0]);
                chk("pc64", opc64, e.pc);
                chk("imm32", oimm32, e.imm[31:0]);
                chk("imm64", oimm64, e.imm);
                chk("type32", oty32, e.ty);
                chk("type64", oty64, e.ty);
                chk("tgt32", otgt32, t[31:0]);
                chk("tgt64", otgt64, t);
            end
        end
    end

    // Hold the word until the DUT takes it; called at a negedge.
    task automatic wait_accept();
        bit done = 0;
        bit ok;
        for (int k = 0; k < 20 && !done; k++) begin
            ok = rdy32 && !flush;
            @(negedge clk);
            if (ok) done = 1;
        end
        in_valid = 1'b0;
        if (!done) begin
            ncmp++;
            nerr++;
            $display("FAIL accept_timeout: got none expected 1");
        end
    endtask

    task automatic send(logic [31:0] w, logic [63:0] pc);
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = pc;
        wait_accept();
    endtask

    logic [31:0] vec [9] = '{
        32'hFE112E23, 32'hFFDFF0EF, 32'h00008067,
        32'h00001517, 32'h12345037, 32'h00B50533,
        32'h0FF0000F, 32'h00502073, 32'h0000007F
    };

    initial begin
        exp_t m;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid32", vld32, 0);
        chk("rst_ready32", rdy32, 1);
        chk("rst_imm32", oimm32, 0);
        chk("rst_tgt32", otgt32, 0);
        chk("rst_instr32", oi32, 0);
        chk("rst_ill32", ill32, 0);
        chk("rst_valid64", vld64, 0);
        chk("rst_ready64", rdy64, 1);
        chk("rst_imm64", oimm64, 0);
        chk("rst_ill64", ill64, 0);

        m = model(32'hFE010113, 64'h100);
        chk("m_I_imm", m.imm, 64'hFFFFFFFFFFFFFFE0);
        chk("m_I_ty", m.ty, 0);
        m = model(32'hFE000EE3, 64'h200);
        chk("m_B_imm", m.imm, 64'hFFFFFFFFFFFFFFFC);
        m = model(32'h300FD073, 64'h0);
        chk("m_CSR_imm", m.imm, 64'h1F);
        chk("m_CSR_ty", m.ty, 5);
        m = model(32'h80000037, 64'h1000);
        chk("m_U_imm", m.imm, 64'hFFFFFFFF80000000);

        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        send(32'hFE010113, 64'h100);
        chk("d_I_imm32", oimm32, 32'hFFFFFFE0);
        chk("d_I_ty32", oty32, 0);
        chk("d_I_tgt32", otgt32, 32'h000000E0);
        send(32'hFE000EE3, 64'h200);
        chk("d_B_imm32", oimm32, 32'hFFFFFFFC);
        chk("d_B_ty32", oty32, 2);
        chk("d_B_tgt32", otgt32, 32'h1FC);
        send(32'h300FD073, 64'h300);
        chk("d_CSR_imm32", oimm32, 32'h1F);
        chk("d_CSR_ty32", oty32, 5);
        send(32'h80000037, 64'h1000);
        chk("d_U_imm64", oimm64, 64'hFFFFFFFF80000000);
        chk("d_U_ty64", oty64, 3);
        chk("d_U_tgt64", otgt64, 64'hFFFFFFFF80001000);
        chk("d_U_imm32", oimm32, 32'h80000000);
        send(32'h00000000, 64'h400);
        chk("d_ILL_ty32", oty32, 7);
        chk("d_ILL_imm32", oimm32, 0);
        chk("d_ILL_cnt32", ill32, 1);
        for (int i = 0; i < 3; i++)
            send(32'h00000000, 64'h404 + 64'(4 * i));
        chk("d_sat_cnt32", ill32, 3);
        chk("d_cnt64", ill64, 4);
        send(32'h00000000, 64'h500);
        chk("d_hold_cnt32", ill32, 3);
        chk("d_cnt64b", ill64, 5);

        for (int i = 0; i < 9; i++)
            send(vec[i], 64'h8000_0000_0000_0000 + 64'(16 * i));
        repeat (2) @(negedge clk);

        out_ready = 1'b0;
        send(32'h00100093, 64'h600);
        send(32'h00200113, 64'h604);
        in_valid = 1'b1;
        in_instr = 32'h00300193;
        in_pc    = 64'h608;
        @(negedge clk);
        chk("bp_ready", rdy32, 0);
        chk("bp_head", oi32, 32'h00100093);
        @(negedge clk);
        chk("bp_stable", oi32, 32'h00100093);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_second", oi32, 32'h00200113);
        wait_accept();
        chk("bp_third", oi32, 32'h00300193);
        repeat (3) @(negedge clk);

        out_ready = 1'b0;
        send(32'h00400213, 64'h700);
        send(32'h00500293, 64'h704);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00000000;
        in_pc    = 64'h708;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid32", vld32, 0);
        chk("fl_ready32", rdy32, 1);
        chk("fl_valid64", vld64, 0);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        out_ready = 1'b0;
        send(32'hFE010113, 64'h900);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_valid32", vld32, 0);
        chk("mr_instr32", oi32, 0);
        chk("mr_imm32", oimm32, 0);
        chk("mr_tgt32", otgt32, 0);
        chk("mr_ill32", ill32, 0);
        chk("mr_instr64", oi64, 0);
        chk("mr_ill64", ill64, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(32'h00000000, 64'hA00);
        send(32'hFFDFF0EF, 64'hA04);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Parametrised, buffered successor to the combinational immediate generator. Accepts fetched 32-bit instruction words with a PC over a valid/ready handshake and derives the immediate type from the opcode itself; no external type select. Produces the XLEN-wide sign- or zero-extended immediate and a precomputed `pc + imm` target, and holds results in a 2-entry output FIFO so decode can stall without a combinational ready path back to fetch. Sits between the IF/ID register and the ID stage.

## Interface
- `XLEN`, 32: datapath width, 32 or 64; immediates are extended to XLEN.
- `CNT_W`, 16: width of the saturating illegal-instruction counter.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  discard all buffered entries and the current input.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  block can accept; equals `count != 2`.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  XLEN  instruction address.
- `out_valid`  out  1  head entry valid; equals `count != 0`.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_instr`  out  32  head instruction.
- `out_pc`  out  XLEN  head PC.
- `out_imm`  out  XLEN  extended immediate.
- `out_imm_type`  out  3  I=0, S=1, B=2, U=3, J=4, CSR=5, NONE=6, ILL=7.
- `out_target`  out  XLEN  `out_pc + out_imm`, modulo 2^XLEN.
- `illegal_cnt`  out  CNT_W  count of accepted ILL words, saturating.

## Operation
- Type decode on `in_instr[6:0]`:
  - I: 0000011, 0010011, 1100111.
  - S: 0100011. B: 1100011. U: 0110111, 0010111. J: 1101111.
  - 1110011: CSR if `instr[14]`=1, else I.
  - NONE: 0110011, 0001111.
  - Any other opcode: ILL.
- Extraction follows the RV32I layouts for I/S/B/U/J; sign bit `instr[31]` extended to XLEN. U is also sign-extended from bit 31 when XLEN=64.
- CSR: `imm = zero-extend(instr[19:15])`. This is new behaviour; it is not I-format.
- NONE and ILL: `imm = 0`, target = pc.
- Push when `in_valid && in_ready && !flush`. Pop when `out_valid && out_ready && !flush`.
- Push and pop in the same cycle: count is unchanged and order is preserved.
- `illegal_cnt` increments on a push of an ILL word and holds at all-ones. `flush` does not clear it.
- Flush: count becomes 0 next cycle. Input in the flush cycle is dropped, and `illegal_cnt` does not count it.

## Timing
- Reset (async assert, sync release): count=0, `out_valid`=0, `in_ready`=1, all FIFO data, `out_*` and `illegal_cnt` = 0.
- Latency 1 cycle: a word pushed in cycle N is visible at the head in cycle N+1 when the FIFO was empty.
- Throughput 1 word/cycle while `out_ready` is held high.
- `in_ready` depends only on registered count; there is no `out_ready`→`in_ready` path. When full, a same-cycle pop does not allow a push.
- Head outputs are stable while `out_valid && !out_ready`.
- Pointers are 1 bit and wrap modulo 2.
- Reset asserted mid-transfer discards all entries immediately.

## Structure
- Package `imm_pkg`:
  - `imm_type_e` (3-bit enum above).
  - Opcode localparams.
  - Entry struct {instr, pc, imm, type, target}, parametrised via XLEN at use site.
- Sub-module `imm_extract`: purely combinational, `#(XLEN)`, instr → {imm, type}. The target adder lives in the top level.
- FIFO (2 entries, rd/wr pointers, count) is inline in `imm_decode_stage`.

## Test plan
- XLEN=32, `in_instr`=32'hFE010113, pc=32'h100 → next cycle: imm=32'hFFFFFFE0, type I, target=32'h000000E0.
- `in_instr`=32'hFE000EE3 (beq -4), pc=32'h200 → imm=32'hFFFFFFFC, type B, target=32'h1FC.
- `in_instr`=32'h300FD073 (csrrwi) → imm=32'h1F, type CSR. `in_instr`=32'h00000000 → type ILL, imm=0, `illegal_cnt` 0→1. With CNT_W=2 and 4 ILL words, the count holds at 3.
- XLEN=64, `in_instr`=32'h80000037, pc=64'h1000 → imm=64'hFFFFFFFF80000000, type U, target=64'hFFFFFFFF80001000.
- Backpressure: `out_ready`=0, offer words A,B,C back-to-back → A,B accepted, `in_ready`=0, C held. Raise `out_ready` → A,B,C emerge in order, one per cycle.
- Two entries buffered, `flush`=1 with `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, dropped word never appears. Reset asserted while 1 entry is buffered → outputs 0 immediately.
